// File: rtl/my_cpu_pkg.sv
// Shared constants for the register file: default entry width and update directions.
package my_cpu_pkg;

    localparam int   DEFAULT_REGISTER_WIDTH = 4;
    localparam logic UPD_INC                = 1'b0;
    localparam logic UPD_DEC                = 1'b1;

endpackage : my_cpu_pkg

// File: rtl/my_register_cell.sv
// One register-file entry: write beats update, +/-1 modulo 2^WIDTH, wrap detect.
// next_o is the value this entry commits at the coming edge, so the top can bypass it.
module my_register_cell
    import my_cpu_pkg::*;
#(
    parameter int WIDTH          = DEFAULT_REGISTER_WIDTH,
    parameter bit HARDWIRED_ZERO = 1'b0
) (
    input  logic             clk_i,
    input  logic             reset_ni,
    input  logic             we_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             upd_en_i,
    input  logic             upd_dir_i,
    output logic [WIDTH-1:0] next_o,
    output logic             wrap_o
);

    generate
        if (HARDWIRED_ZERO) begin : g_zero
            assign next_o = '0;
            assign wrap_o = 1'b0;
        end else begin : g_reg
            logic [WIDTH-1:0] value_q;
            logic [WIDTH-1:0] value_d;
            logic             wrap_d;

            // The write wins outright: a colliding update neither commits nor flags a wrap.
            always_comb begin
                value_d = value_q;
                wrap_d  = 1'b0;
                if (we_i) begin
                    value_d = wdata_i;
                end else if (upd_en_i) begin
                    if (upd_dir_i == UPD_INC) begin
                        value_d = value_q + 1'b1;
                        wrap_d  = &value_q;
                    end else begin
                        value_d = value_q - 1'b1;
                        wrap_d  = ~|value_q;
                    end
                end
            end

            always_ff @(posedge clk_i) begin
                if (!reset_ni) begin
                    value_q <= '0;
                end else begin
                    value_q <= value_d;
                end
            end

            assign next_o = value_d;
            assign wrap_o = wrap_d;
        end
    endgenerate

endmodule : my_register_cell

// File: rtl/my_register_file.sv
// Register file with one write port, one +/-1 update port and two registered,
// write-first read ports. Define MY_REGISTER_FILE_ZERO_REG_EN to hardwire entry 0 to zero.
module my_register_file
    import my_cpu_pkg::*;
#(
    parameter int REGISTER_WIDTH = DEFAULT_REGISTER_WIDTH,
    parameter int NUM_REGISTERS  = 4,
    parameter int ADDR_WIDTH     = $clog2(NUM_REGISTERS)
) (
    input  logic                      clk_i,
    input  logic                      reset_ni,
    input  logic                      we_i,
    input  logic [ADDR_WIDTH-1:0]     waddr_i,
    input  logic [REGISTER_WIDTH-1:0] wdata_i,
    input  logic                      upd_en_i,
    input  logic [ADDR_WIDTH-1:0]     upd_addr_i,
    input  logic                      upd_dir_i,
    input  logic [ADDR_WIDTH-1:0]     raddr_a_i,
    input  logic [ADDR_WIDTH-1:0]     raddr_b_i,
    output logic [REGISTER_WIDTH-1:0] rdata_a_o,
    output logic [REGISTER_WIDTH-1:0] rdata_b_o,
    output logic                      wrap_o
);

`ifdef MY_REGISTER_FILE_ZERO_REG_EN
    localparam bit ZERO_REG = 1'b1;
`else
    localparam bit ZERO_REG = 1'b0;
`endif

    logic [REGISTER_WIDTH-1:0] next_vals [NUM_REGISTERS];
    logic [NUM_REGISTERS-1:0]  wrap_vec;

    logic [REGISTER_WIDTH-1:0] rdata_a_q, rdata_a_d;
    logic [REGISTER_WIDTH-1:0] rdata_b_q, rdata_b_d;
    logic                      wrap_q, wrap_d;

    for (genvar g = 0; g < NUM_REGISTERS; g++) begin : g_cell
        my_register_cell #(
            .WIDTH          (REGISTER_WIDTH),
            .HARDWIRED_ZERO (ZERO_REG && (g == 0))
        ) u_cell (
            .clk_i     (clk_i),
            .reset_ni  (reset_ni),
            .we_i      (we_i && (waddr_i == ADDR_WIDTH'(g))),
            .wdata_i   (wdata_i),
            .upd_en_i  (upd_en_i && (upd_addr_i == ADDR_WIDTH'(g))),
            .upd_dir_i (upd_dir_i),
            .next_o    (next_vals[g]),
            .wrap_o    (wrap_vec[g])
        );
    end

    // Reading each cell's next value gives write-first bypass for free.
    always_comb begin
        rdata_a_d = next_vals[raddr_a_i];
        rdata_b_d = next_vals[raddr_b_i];
        wrap_d    = |wrap_vec;
    end

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            rdata_a_q <= '0;
            rdata_b_q <= '0;
            wrap_q    <= 1'b0;
        end else begin
            rdata_a_q <= rdata_a_d;
            rdata_b_q <= rdata_b_d;
            wrap_q    <= wrap_d;
        end
    end

    assign rdata_a_o = rdata_a_q;
    assign rdata_b_o = rdata_b_q;
    assign wrap_o    = wrap_q;

endmodule : my_register_file

// File: tb/tb_my_register_file.sv
// Directed, table-driven bench for my_register_file (4 entries x 4 bits);
// expectations follow MY_REGISTER_FILE_ZERO_REG_EN when it is defined.
module tb_my_register_file;

    localparam int W = 4;
    localparam int A = 2;

    typedef struct {
        logic         we;
        logic [A-1:0] waddr;
        logic [W-1:0] wdata;
        logic         upd_en;
        logic [A-1:0] upd_addr;
        logic         upd_dir;
        logic [A-1:0] ra;
        logic [A-1:0] rb;
        logic [W-1:0] ea;
        logic [W-1:0] eb;
        logic         ew;
    } vec_t;

    logic         clk = 1'b0;
    logic         reset_ni;
    logic         we_i, upd_en_i, upd_dir_i;
    logic [A-1:0] waddr_i, upd_addr_i, raddr_a_i, raddr_b_i;
    logic [W-1:0] wdata_i;
    logic [W-1:0] rdata_a_o, rdata_b_o;
    logic         wrap_o;

    int checks = 0;
    int errors = 0;
    logic [2*W:0] exp_q [$];
    vec_t         vecs [$];

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    my_register_file #(.REGISTER_WIDTH(W), .NUM_REGISTERS(4)) dut (
        .clk_i      (clk),
        .reset_ni   (reset_ni),
        .we_i       (we_i),
        .waddr_i    (waddr_i),
        .wdata_i    (wdata_i),
        .upd_en_i   (upd_en_i),
        .upd_addr_i (upd_addr_i),
        .upd_dir_i  (upd_dir_i),
        .raddr_a_i  (raddr_a_i),
        .raddr_b_i  (raddr_b_i),
        .rdata_a_o  (rdata_a_o),
        .rdata_b_o  (rdata_b_o),
        .wrap_o     (wrap_o)
    );

    // ---------------- driver tasks ----------------
    function automatic vec_t mk(logic we, int wa, int wd, logic ue, int ua, logic ud,
                                int ra, int rb, int ea, int eb, logic ew);
        vec_t v;
        v.we = we;  v.waddr = A'(wa);  v.wdata = W'(wd);
        v.upd_en = ue;  v.upd_addr = A'(ua);  v.upd_dir = ud;
        v.ra = A'(ra);  v.rb = A'(rb);
        v.ea = W'(ea);  v.eb = W'(eb);  v.ew = ew;
        return v;
    endfunction

    task automatic drive(input vec_t v, input logic rst_n);
        @(negedge clk);
        reset_ni   = rst_n;
        we_i       = v.we;
        waddr_i    = v.waddr;
        wdata_i    = v.wdata;
        upd_en_i   = v.upd_en;
        upd_addr_i = v.upd_addr;
        upd_dir_i  = v.upd_dir;
        raddr_a_i  = v.ra;
        raddr_b_i  = v.rb;
        exp_q.push_back({v.ea, v.eb, v.ew});
    endtask

    // ---------------- scoreboard ----------------
    task automatic check_one(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic sample(input string tag);
        logic [2*W:0] e;
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check_one({tag, " rdata_a"}, rdata_a_o, e[2*W:W+1]);
        check_one({tag, " rdata_b"}, rdata_b_o, e[W:1]);
        check_one({tag, " wrap"}, W'(wrap_o), W'(e[0]));
    endtask

    // ---------------- test ----------------
    initial begin
        logic [W-1:0] z_dec, z_w7;
        logic         z_wrap;
`ifdef MY_REGISTER_FILE_ZERO_REG_EN
        z_dec = 4'h0;  z_w7 = 4'h0;  z_wrap = 1'b0;
`else
        z_dec = 4'hF;  z_w7 = 4'h7;  z_wrap = 1'b1;
`endif
        //              we wa wd  ue ua ud  ra rb  ea     eb   ew
        vecs.push_back(mk(1, 2, 'hA, 0, 0, 0, 2, 2, 'hA,  'hA, 0));  // write + same-cycle read bypass
        vecs.push_back(mk(0, 0, 0,   0, 0, 0, 2, 0, 'hA,  0,   0));
        vecs.push_back(mk(1, 1, 'hF, 0, 0, 0, 1, 2, 'hF,  'hA, 0));
        vecs.push_back(mk(0, 0, 0,   1, 1, 0, 1, 3, 0,    0,   1));  // inc F -> 0 wraps
        vecs.push_back(mk(0, 0, 0,   0, 0, 0, 1, 2, 0,    'hA, 0));  // wrap is a single pulse
        vecs.push_back(mk(0, 0, 0,   1, 1, 1, 1, 1, 'hF,  'hF, 1));  // dec 0 -> F wraps
        vecs.push_back(mk(0, 0, 0,   0, 0, 0, 1, 0, 'hF,  0,   0));
        vecs.push_back(mk(1, 3, 5,   1, 3, 1, 3, 3, 5,    5,   0));  // same address: write wins
        vecs.push_back(mk(1, 3, 7,   1, 1, 1, 3, 1, 7,    'hE, 0));  // different addresses: both apply
        vecs.push_back(mk(0, 0, 0,   1, 3, 0, 3, 2, 8,    'hA, 0));
        vecs.push_back(mk(0, 0, 0,   1, 0, 1, 0, 1, z_dec,'hE, z_wrap));
        vecs.push_back(mk(1, 0, 7,   0, 0, 0, 0, 0, z_w7, z_w7,0));
        vecs.push_back(mk(0, 0, 0,   0, 0, 0, 0, 3, z_w7, 8,   0));
        vecs.push_back(mk(1, 2, 3,   1, 2, 0, 2, 2, 3,    3,   0));
        vecs.push_back(mk(1, 2, 'hF, 0, 0, 0, 2, 1, 'hF,  'hE, 0));
        vecs.push_back(mk(1, 2, 0,   1, 2, 0, 2, 2, 0,    0,   0));  // dropped update from F: no wrap

        // One-cycle reset with all inputs idle.
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0);
        sample("reset");

        foreach (vecs[i]) begin
            drive(vecs[i], 1'b1);
            sample($sformatf("vec%0d", i));
        end

        // Reset coinciding with a write of 0x9 to entry 1: write lost, all entries cleared.
        drive(mk(1, 1, 9, 1, 3, 0, 1, 3, 0, 0, 0), 1'b0);
        sample("rst_write");
        drive(mk(0, 0, 0, 0, 0, 0, 1, 3, 0, 0, 0), 1'b1);
        sample("post_rst");
        // First cycle out of reset accepts writes immediately.
        drive(mk(1, 1, 6, 1, 2, 1, 1, 2, 6, 'hF, 1), 1'b1);
        sample("post_rst_op");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_my_register_file
